// File: rtl/legv8_pkg.sv
// Shared LEGv8 execute-stage definitions: datapath width, multiplier
// iteration count and multiplier controller state encoding.
package legv8_pkg;

  localparam int XLEN      = 64;
  localparam int MUL_ITERS = 64;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_seq_64_cla.sv
// 64-bit three-level carry-lookahead adder: 4-bit groups, 16-bit super
// groups and a top-level lookahead across the four super groups.
module mul_seq_64_cla
  import legv8_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            Cin,
  output logic [XLEN-1:0] sum_o,
  output logic            Cout
);

  logic [XLEN-1:0] g_s;
  logic [XLEN-1:0] p_s;
  logic [15:0]     gg_s;
  logic [15:0]     gp_s;
  logic [3:0]      sgg_s;
  logic [3:0]      sgp_s;
  logic [4:0]      sc_s;
  logic [15:0]     gc_s;
  logic [XLEN-1:0] bc_s;

  // Generate/propagate terms and the three lookahead levels
  always_comb begin
    g_s   = a_i & b_i;
    p_s   = a_i ^ b_i;
    gg_s  = 16'd0;
    gp_s  = 16'd0;
    sgg_s = 4'd0;
    sgp_s = 4'd0;
    sc_s  = 5'd0;
    gc_s  = 16'd0;
    bc_s  = {XLEN{1'b0}};

    for (int i = 0; i < 16; i++) begin
      gg_s[i] = g_s[4*i+3]
              | (p_s[4*i+3] & g_s[4*i+2])
              | (p_s[4*i+3] & p_s[4*i+2] & g_s[4*i+1])
              | ((&p_s[4*i+1 +: 3]) & g_s[4*i]);
      gp_s[i] = &p_s[4*i +: 4];
    end

    for (int s = 0; s < 4; s++) begin
      sgg_s[s] = gg_s[4*s+3]
               | (gp_s[4*s+3] & gg_s[4*s+2])
               | (gp_s[4*s+3] & gp_s[4*s+2] & gg_s[4*s+1])
               | ((&gp_s[4*s+1 +: 3]) & gg_s[4*s]);
      sgp_s[s] = &gp_s[4*s +: 4];
    end

    // Top level: each super-group carry is a flat sum of products
    sc_s[0] = Cin;
    sc_s[1] = sgg_s[0] | (sgp_s[0] & Cin);
    sc_s[2] = sgg_s[1] | (sgp_s[1] & sgg_s[0]) | (sgp_s[1] & sgp_s[0] & Cin);
    sc_s[3] = sgg_s[2] | (sgp_s[2] & sgg_s[1]) | (sgp_s[2] & sgp_s[1] & sgg_s[0])
            | (sgp_s[2] & sgp_s[1] & sgp_s[0] & Cin);
    sc_s[4] = sgg_s[3] | (sgp_s[3] & sgg_s[2]) | (sgp_s[3] & sgp_s[2] & sgg_s[1])
            | (sgp_s[3] & sgp_s[2] & sgp_s[1] & sgg_s[0])
            | ((&sgp_s) & Cin);

    for (int s = 0; s < 4; s++) begin
      gc_s[4*s]   = sc_s[s];
      gc_s[4*s+1] = gg_s[4*s] | (gp_s[4*s] & sc_s[s]);
      gc_s[4*s+2] = gg_s[4*s+1] | (gp_s[4*s+1] & gg_s[4*s])
                  | (gp_s[4*s+1] & gp_s[4*s] & sc_s[s]);
      gc_s[4*s+3] = gg_s[4*s+2] | (gp_s[4*s+2] & gg_s[4*s+1])
                  | (gp_s[4*s+2] & gp_s[4*s+1] & gg_s[4*s])
                  | (gp_s[4*s+2] & gp_s[4*s+1] & gp_s[4*s] & sc_s[s]);
    end

    for (int i = 0; i < 16; i++) begin
      bc_s[4*i]   = gc_s[i];
      bc_s[4*i+1] = g_s[4*i] | (p_s[4*i] & gc_s[i]);
      bc_s[4*i+2] = g_s[4*i+1] | (p_s[4*i+1] & g_s[4*i])
                  | (p_s[4*i+1] & p_s[4*i] & gc_s[i]);
      bc_s[4*i+3] = g_s[4*i+2] | (p_s[4*i+2] & g_s[4*i+1])
                  | (p_s[4*i+2] & p_s[4*i+1] & g_s[4*i])
                  | (p_s[4*i+2] & p_s[4*i+1] & p_s[4*i] & gc_s[i]);
    end
  end

  assign sum_o = p_s ^ bc_s;
  assign Cout  = sc_s[4];

endmodule

// File: rtl/mul_seq_64.sv
// Iterative 64x64 unsigned shift-add multiplier producing the full 128-bit
// product, one partial-product add per cycle through the lookahead adder.
module mul_seq_64
  import legv8_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITERS - 1);

  mul_state_t       state_q;
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] mcand_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] addend_s;
  logic [WIDTH-1:0] sum_s;
  logic             c_s;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mplier_d;
  logic [CNT_W-1:0] cnt_d;

  mul_seq_64_cla u_add (
    .a_i   (acc_q),
    .b_i   (addend_s),
    .Cin   (1'b0),
    .sum_o (sum_s),
    .Cout  (c_s)
  );

  // One shift-add step: the adder carry becomes the new accumulator MSB
  always_comb begin
    addend_s = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
    acc_d    = {c_s, sum_s[WIDTH-1:1]};
    mplier_d = {sum_s[0], mplier_q[WIDTH-1:1]};
    if (cnt_q == LAST_CNT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Controller and datapath registers; flush leaves operand/product data intact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      acc_q    <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else if (flush) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            state_q  <= BUSY;
            ready_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_d;
          ready_q  <= 1'b0;
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= BUSY;
            done_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign prod_hi = acc_q;
  assign prod_lo = mplier_q;

endmodule

// File: tb/tb_mul_seq_64.sv
// Directed bench for mul_seq_64: vector table plus handshake, reset and
// flush sequences, all with hand-computed products and cycle counts.
module tb_mul_seq_64;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [63:0] a;
  logic [63:0] b;
  logic        ready;
  logic        done;
  logic [63:0] prod_lo;
  logic [63:0] prod_hi;

  int checks;
  int errors;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] hi;
    logic [63:0] lo;
  } vec_t;

  vec_t vecs[8];

  mul_seq_64 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flush   (flush),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .prod_lo (prod_lo),
    .prod_hi (prod_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one multiply, return the product and the edges from accept to done
  task automatic run_mul(input logic [63:0] av, input logic [63:0] bv,
                         output logic [63:0] hi, output logic [63:0] lo, output int lat);
    int w;
    w = 0;
    while (!ready && w < 200) begin
      tick();
      w++;
    end
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    hi = prod_hi;
    lo = prod_lo;
  endtask

  initial begin
    logic [63:0] hi;
    logic [63:0] lo;
    int lat;
    int pulses;
    int t1;
    int t2;
    logic [127:0] p1;
    logic [127:0] p2;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    a = 64'd0;
    b = 64'd0;

    vecs[0] = '{64'd3, 64'd5, 64'd0, 64'd15};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001};
    vecs[2] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 64'd0};
    vecs[3] = '{64'd0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0};
    vecs[6] = '{64'h1_0000_0001, 64'h1_0000_0001, 64'd1, 64'h0000_0002_0000_0001};
    vecs[7] = '{64'hDEAD_BEEF, 64'd1, 64'd0, 64'hDEAD_BEEF};

    tick();
    tick();
    check("reset_ready", {127'd0, ready}, 128'd1);
    check("reset_done", {127'd0, done}, 128'd0);
    check("reset_prod", {prod_hi, prod_lo}, 128'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_mul(vecs[i].a, vecs[i].b, hi, lo, lat);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd64);
      check($sformatf("vec%0d_prod", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
      check($sformatf("vec%0d_ready_during_done", i), {127'd0, ready}, 128'd0);
      tick();
      check($sformatf("vec%0d_ready_after", i), {127'd0, ready}, 128'd1);
      check($sformatf("vec%0d_done_pulse", i), {127'd0, done}, 128'd0);
    end

    // start held high with changing operands: only the first pair counts until IDLE
    a = 64'd7;
    b = 64'd9;
    start = 1'b1;
    tick();
    a = 64'd11;
    b = 64'd13;
    pulses = 0;
    t1 = 0;
    t2 = 0;
    p1 = 128'd0;
    p2 = 128'd0;
    for (int t = 1; t <= 200; t++) begin
      tick();
      if (t >= 66) start = 1'b0;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          t1 = t;
          p1 = {prod_hi, prod_lo};
        end else begin
          t2 = t;
          p2 = {prod_hi, prod_lo};
        end
      end
    end
    start = 1'b0;
    check("hold_pulses", 128'(pulses), 128'd2);
    check("hold_first_time", 128'(t1), 128'd64);
    check("hold_first_prod", p1, 128'd63);
    check("hold_second_time", 128'(t2), 128'd130);
    check("hold_second_prod", p2, 128'd143);

    // Asynchronous reset in the middle of iteration 30
    run_mul(64'd1, 64'd1, hi, lo, lat);
    tick();
    a = 64'd5;
    b = 64'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 30; t++) tick();
    rst_n = 1'b0;
    #1;
    check("midreset_ready", {127'd0, ready}, 128'd1);
    check("midreset_done", {127'd0, done}, 128'd0);
    check("midreset_prod", {prod_hi, prod_lo}, 128'd0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int t = 0; t < 80; t++) begin
      tick();
      if (done) pulses++;
    end
    check("midreset_no_done", 128'(pulses), 128'd0);
    run_mul(64'd7, 64'd9, hi, lo, lat);
    check("after_reset_prod", {hi, lo}, 128'd63);
    check("after_reset_latency", 128'(lat), 128'd64);
    tick();

    // Flush on the final iteration beats the BUSY->DONE transition
    a = 64'd3;
    b = 64'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 63; t++) tick();
    check("flush_pre_ready", {127'd0, ready}, 128'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_done", {127'd0, done}, 128'd0);
    check("flush_ready", {127'd0, ready}, 128'd1);
    pulses = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (done) pulses++;
    end
    check("flush_no_late_done", 128'(pulses), 128'd0);

    // flush together with start in IDLE is not an accept
    a = 64'd2;
    b = 64'd2;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_ready", {127'd0, ready}, 128'd1);
    pulses = 0;
    for (int t = 0; t < 70; t++) begin
      tick();
      if (done) pulses++;
    end
    check("flush_start_no_done", 128'(pulses), 128'd0);
    run_mul(64'd6, 64'd7, hi, lo, lat);
    check("post_flush_prod", {hi, lo}, 128'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
